// File: rtl/neuron_lif_pkg.sv
// Shared types and width helpers for the time-multiplexed LIF neuron layer.
// Contents:
//   state_t        - layer sequencer states (IDLE/RUN/DONE)
//   idx_bits()     - width of the neuron index (never below 1)
//   membrane_bits()- default signed membrane width for a synapse count
//   psp_bits()     - signed width that holds the synaptic sum -SYNAPSES..+SYNAPSES
package neuron_lif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_bits(input int neurons);
    return (neurons > 1) ? $clog2(neurons) : 1;
  endfunction

  function automatic int membrane_bits(input int synapses);
    return $clog2(synapses) + 2;
  endfunction

  function automatic int psp_bits(input int synapses);
    return $clog2(synapses) + 2;
  endfunction

endpackage

// File: rtl/neuron_lif_layer_if.sv
// Bus between the layer sequencer and its environment (spike-input shift
// register, weight store, output spike bus).
// Signals:
//   start         begin one timestep (honoured only when the layer is idle)
//   inputs        synaptic spike vector, latched on an accepted start
//   busy          layer is evaluating or presenting a result
//   neuron_idx    neuron currently evaluated; weights are looked up from it
//   weights       weight vector for neuron_idx, same cycle
//   shift         decay shift amount
//   threshold     unsigned firing threshold
//   spikes        spike vector of the last completed timestep
//   spikes_valid  one-cycle pulse when spikes is updated
//   membrane_out  new membrane of neuron_idx (debug, 0 outside evaluation)
// Modports: master = environment, slave = layer.
interface neuron_lif_layer_if
  import neuron_lif_pkg::*;
#(
  parameter int SYNAPSES       = 8,
  parameter int NEURONS        = 4,
  parameter int MEMBRANE_BITS  = membrane_bits(SYNAPSES),
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
);
  localparam int IDX_W = idx_bits(NEURONS);

  logic                             start;
  logic        [SYNAPSES-1:0]       inputs;
  logic                             busy;
  logic        [IDX_W-1:0]          neuron_idx;
  logic        [SYNAPSES-1:0]       weights;
  logic        [2:0]                shift;
  logic        [THRESHOLD_BITS-1:0] threshold;
  logic        [NEURONS-1:0]        spikes;
  logic                             spikes_valid;
  logic signed [MEMBRANE_BITS-1:0]  membrane_out;

  modport master (
    output start, inputs, weights, shift, threshold,
    input  busy, neuron_idx, spikes, spikes_valid, membrane_out
  );

  modport slave (
    input  start, inputs, weights, shift, threshold,
    output busy, neuron_idx, spikes, spikes_valid, membrane_out
  );

endinterface

// File: rtl/lif_datapath.sv
// Combinational leaky integrate-and-fire update for one neuron.
// Ports:
//   inputs, weights  synaptic spikes and binary weights (1 = excitatory)
//   u                current signed membrane
//   shift            decay shift (0 = no leak)
//   threshold        unsigned firing threshold
//   u_new            next membrane (reset by subtraction on a spike)
//   spike            fire decision
module lif_datapath
  import neuron_lif_pkg::*;
#(
  parameter int SYNAPSES       = 8,
  parameter int MEMBRANE_BITS  = membrane_bits(SYNAPSES),
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
) (
  input  logic        [SYNAPSES-1:0]       inputs,
  input  logic        [SYNAPSES-1:0]       weights,
  input  logic signed [MEMBRANE_BITS-1:0]  u,
  input  logic        [2:0]                shift,
  input  logic        [THRESHOLD_BITS-1:0] threshold,
  output logic signed [MEMBRANE_BITS-1:0]  u_new,
  output logic                             spike
);
  localparam int PSP_W = psp_bits(SYNAPSES);
  localparam int ACC_W = ((MEMBRANE_BITS > PSP_W) ? MEMBRANE_BITS : PSP_W) + 1;
  localparam logic signed [ACC_W-1:0] MEM_MAX = ACC_W'((2 ** (MEMBRANE_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MEM_MIN = ACC_W'(-(2 ** (MEMBRANE_BITS - 1)));

  function automatic logic signed [MEMBRANE_BITS-1:0] sat_mem(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [ACC_W-1:0] c;
    c = v;
    if (v > MEM_MAX) c = MEM_MAX;
    else if (v < MEM_MIN) c = MEM_MIN;
    return c[MEMBRANE_BITS-1:0];
  endfunction

  logic signed [PSP_W-1:0]         psp;
  logic signed [MEMBRANE_BITS-1:0] decayed;
  logic signed [ACC_W-1:0]         acc;
  logic signed [MEMBRANE_BITS-1:0] acc_sat;
  logic signed [MEMBRANE_BITS-1:0] thr_s;

  always_comb begin
    psp = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      if (inputs[i]) psp = psp + (weights[i] ? PSP_W'(1) : PSP_W'(-1));
    end
  end

  // u - (u >>> s) lies between 0 and u, so it cannot overflow the membrane width.
  assign decayed = (shift == 3'd0) ? u : (u - (u >>> shift));
  assign acc     = ACC_W'(decayed) + ACC_W'(psp);
  assign acc_sat = sat_mem(acc);
  assign thr_s   = MEMBRANE_BITS'({1'b0, threshold});
  assign spike   = (acc_sat >= thr_s);
  // acc_sat >= thr_s >= 0 on a spike, so the subtraction stays in range.
  assign u_new   = spike ? (acc_sat - thr_s) : acc_sat;

endmodule

// File: rtl/neuron_lif_layer.sv
// Layer of NEURONS leaky integrate-and-fire neurons sharing one synaptic
// input vector and one lif_datapath. A timestep evaluates one neuron per
// cycle (IDLE -> RUN x NEURONS -> DONE) and keeps the membranes in a
// register file.
// Ports:
//   clk    clock
//   reset  synchronous active-high; discards a partial timestep
//   bus    neuron_lif_layer_if.slave (start/inputs/weights/shift/threshold in,
//          busy/neuron_idx/spikes/spikes_valid/membrane_out out)
// Configuration:
//   NEURON_LIF_LAYER_REFRACTORY_EN  when defined, a neuron that fires is held
//   silent with membrane 0 for the next REFRACTORY timesteps.
module neuron_lif_layer
  import neuron_lif_pkg::*;
#(
  parameter int SYNAPSES       = 8,
  parameter int NEURONS        = 4,
  parameter int MEMBRANE_BITS  = membrane_bits(SYNAPSES),
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
  parameter int REFRACTORY     = 2
) (
  input logic                clk,
  input logic                reset,
  neuron_lif_layer_if.slave  bus
);
  localparam int IDX_W = idx_bits(NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

  state_t state, state_next;

  logic        [IDX_W-1:0]         idx;
  logic        [SYNAPSES-1:0]      inputs_q;
  logic signed [MEMBRANE_BITS-1:0] mem [NEURONS];
  logic        [NEURONS-1:0]       spk_work;
  logic        [NEURONS-1:0]       spk_work_next;
  logic        [NEURONS-1:0]       spikes_q;

  logic signed [MEMBRANE_BITS-1:0] u_cur;
  logic signed [MEMBRANE_BITS-1:0] dp_u_new;
  logic signed [MEMBRANE_BITS-1:0] u_new;
  logic                            dp_spike;
  logic                            spike;
  logic                            in_refr;
  logic                            last;

  assign last  = (idx == LAST_IDX);
  assign u_cur = mem[idx];

  lif_datapath #(
    .SYNAPSES       (SYNAPSES),
    .MEMBRANE_BITS  (MEMBRANE_BITS),
    .THRESHOLD_BITS (THRESHOLD_BITS)
  ) u_datapath (
    .inputs    (inputs_q),
    .weights   (bus.weights),
    .u         (u_cur),
    .shift     (bus.shift),
    .threshold (bus.threshold),
    .u_new     (dp_u_new),
    .spike     (dp_spike)
  );

`ifdef NEURON_LIF_LAYER_REFRACTORY_EN
  localparam int REF_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  logic [REF_W-1:0] refr [NEURONS];

  assign in_refr = (refr[idx] != '0);

  // A silenced evaluation only counts down; it can never reload the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NEURONS; n++) refr[n] <= '0;
    end else if (state == RUN) begin
      if (in_refr) refr[idx] <= refr[idx] - 1'b1;
      else if (dp_spike) refr[idx] <= REF_W'(REFRACTORY);
    end
  end
`else
  logic unused_refractory;
  assign unused_refractory = |REFRACTORY;
  assign in_refr = 1'b0;
`endif

  assign u_new = in_refr ? '0 : dp_u_new;
  assign spike = dp_spike & ~in_refr;

  always_comb begin
    spk_work_next      = spk_work;
    spk_work_next[idx] = spike;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.busy         = 1'b0;
    bus.spikes_valid = 1'b0;
    bus.membrane_out = '0;
    unique case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        bus.busy         = 1'b1;
        bus.membrane_out = u_new;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.busy         = 1'b1;
        bus.spikes_valid = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Spike bits collect in spk_work and are published together as the
  // sequencer leaves RUN, so spikes changes only when spikes_valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      spk_work <= '0;
      spikes_q <= '0;
      for (int n = 0; n < NEURONS; n++) mem[n] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            idx      <= '0;
            inputs_q <= bus.inputs;
            spk_work <= '0;
          end
        end
        RUN: begin
          mem[idx] <= u_new;
          spk_work <= spk_work_next;
          if (last) spikes_q <= spk_work_next;
          else      idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.neuron_idx = idx;
  assign bus.spikes     = spikes_q;

endmodule

// File: tb/tb_neuron_lif_layer.sv
module tb_neuron_lif_layer;
  localparam int S  = 8;
  localparam int N  = 4;
  localparam int MB = 5;
  localparam int TB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  neuron_lif_layer_if #(
    .SYNAPSES(S), .NEURONS(N), .MEMBRANE_BITS(MB), .THRESHOLD_BITS(TB)
  ) bus ();

  neuron_lif_layer #(
    .SYNAPSES(S), .NEURONS(N), .MEMBRANE_BITS(MB), .THRESHOLD_BITS(TB), .REFRACTORY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [S-1:0] w_tab [N];
  assign bus.weights = w_tab[bus.neuron_idx];

  typedef struct {
    int idx;
    int mem;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] spk_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  sb_mute = 1'b0;
  int  run_len = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Monitor: pops the scoreboard on every evaluation cycle and on every result pulse.
  always @(negedge clk) begin
    if (reset || sb_mute) begin
      run_len = 0;
    end else if (bus.busy) begin
      run_len++;
      if (!bus.spikes_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_eval");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("neuron_idx", int'(bus.neuron_idx), e.idx);
          check($sformatf("membrane[%0d]", e.idx), int'(bus.membrane_out), e.mem);
        end
      end else begin
        check("busy_cycles_to_valid", run_len, N + 1);
        if (spk_q.size() == 0) fail_now("unexpected_valid");
        else check("spikes", int'(bus.spikes), int'(spk_q.pop_front()));
        run_len = 0;
      end
    end else if (bus.spikes_valid) begin
      fail_now("valid_without_busy");
    end
  end

  task automatic set_w(input logic [S-1:0] w0, input logic [S-1:0] w1,
                       input logic [S-1:0] w2, input logic [S-1:0] w3);
    w_tab[0] = w0; w_tab[1] = w1; w_tab[2] = w2; w_tab[3] = w3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One timestep; poke pulses start in cycle 2 where it must be ignored.
  task automatic run_ts(input logic [S-1:0] in_v, input logic [2:0] sh,
                        input logic [TB-1:0] thr, input int m0, input int m1,
                        input int m2, input int m3, input logic [N-1:0] spk,
                        input bit poke);
    int ms[4] = '{m0, m1, m2, m3};
    int waited = 0;
    for (int k = 0; k < N; k++) exp_q.push_back('{idx: k, mem: ms[k]});
    spk_q.push_back(spk);
    bus.inputs    = in_v;
    bus.shift     = sh;
    bus.threshold = thr;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.inputs = ~in_v;
    @(negedge clk);
    check("busy_cycle1", int'(bus.busy), 1);
    if (poke) begin
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    while (!bus.spikes_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.spikes_valid) begin
      fail_now("timeout_spikes_valid");
      exp_q.delete();
      spk_q.delete();
    end
    @(negedge clk);
    check("busy_after_done", int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bus.start = 1'b0;
    bus.inputs = '0;
    bus.shift = '0;
    bus.threshold = '0;
    set_w(8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_valid", int'(bus.spikes_valid), 0);
    check("reset_spikes", int'(bus.spikes), 0);
    check("reset_idx", int'(bus.neuron_idx), 0);
    check("reset_membrane_out", int'(bus.membrane_out), 0);

    // Excitatory drive, saturation at +15, reset by subtraction; stray start ignored.
    set_w(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_ts(8'hFF, 3'd0, 4'd10, 8, 8, 8, 8, 4'b0000, 1'b1);
    run_ts(8'hFF, 3'd0, 4'd10, 5, 5, 5, 5, 4'b1111, 1'b0);
`ifdef NEURON_LIF_LAYER_REFRACTORY_EN
    run_ts(8'hFF, 3'd0, 4'd10, 0, 0, 0, 0, 4'b0000, 1'b0);
    run_ts(8'hFF, 3'd0, 4'd10, 0, 0, 0, 0, 4'b0000, 1'b0);
    run_ts(8'hFF, 3'd0, 4'd10, 8, 8, 8, 8, 4'b0000, 1'b0);
`else
    run_ts(8'hFF, 3'd0, 4'd10, 3, 3, 3, 3, 4'b1111, 1'b0);
`endif

    // Mixed weights: psp = +3 - 1 = 2 per timestep.
    do_reset();
    set_w(8'h07, 8'h07, 8'h07, 8'h07);
    run_ts(8'h0F, 3'd0, 4'd3, 2, 2, 2, 2, 4'b0000, 1'b0);
    run_ts(8'h0F, 3'd0, 4'd3, 1, 1, 1, 1, 4'b1111, 1'b0);
    repeat (3) @(negedge clk);
    check("spikes_hold", int'(bus.spikes), 4'hF);
    check("membrane_out_idle", int'(bus.membrane_out), 0);

    // Negative saturation at -16, then leak of a negative membrane.
    do_reset();
    set_w(8'h00, 8'h00, 8'h00, 8'h00);
    run_ts(8'hFF, 3'd0, 4'd10, -8, -8, -8, -8, 4'b0000, 1'b0);
    run_ts(8'hFF, 3'd0, 4'd10, -16, -16, -16, -16, 4'b0000, 1'b0);
    run_ts(8'hFF, 3'd0, 4'd10, -16, -16, -16, -16, 4'b0000, 1'b0);
    run_ts(8'h00, 3'd1, 4'd10, -8, -8, -8, -8, 4'b0000, 1'b0);

    // Leak of a positive membrane: no leak with shift 0, halving with shift 1.
    do_reset();
    set_w(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_ts(8'hFF, 3'd0, 4'd15, 8, 8, 8, 8, 4'b0000, 1'b0);
    run_ts(8'h00, 3'd0, 4'd15, 8, 8, 8, 8, 4'b0000, 1'b0);
    run_ts(8'h00, 3'd1, 4'd15, 4, 4, 4, 4, 4'b0000, 1'b0);
    run_ts(8'h00, 3'd1, 4'd15, 2, 2, 2, 2, 4'b0000, 1'b0);
    run_ts(8'h00, 3'd1, 4'd15, 1, 1, 1, 1, 4'b0000, 1'b0);
    run_ts(8'h00, 3'd1, 4'd15, 1, 1, 1, 1, 4'b0000, 1'b0);

    // Per-neuron weights: only neuron 0 reaches threshold 8.
    do_reset();
    set_w(8'hFF, 8'h00, 8'h00, 8'h00);
    run_ts(8'hFF, 3'd0, 4'd8, 0, -8, -8, -8, 4'b0001, 1'b0);

    // Reset in cycle 2 of a timestep discards it and clears every membrane.
    do_reset();
    set_w(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_ts(8'hFF, 3'd0, 4'd15, 8, 8, 8, 8, 4'b0000, 1'b0);
    sb_mute = 1'b1;
    bus.inputs = 8'hFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_idx", int'(bus.neuron_idx), 0);
    check("midreset_membrane_out", int'(bus.membrane_out), 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.spikes_valid || bus.busy) pulses++;
    end
    check("midreset_no_activity", pulses, 0);
    sb_mute = 1'b0;
    run_ts(8'h00, 3'd0, 4'd15, 0, 0, 0, 0, 4'b0000, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size() + spk_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
